alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Clocked ARM data-processing ALU with an iterative shift-add multiplier,
// an architectural NZCV register and valid/ready handshakes on both sides.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic             is_mul,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [WIDTH-1:0]   result_r, result_nxt_s;
    logic               wr_en_r, wr_en_nxt_s;
    logic [3:0]         flags_r, flags_nxt_s;
    logic               out_valid_r, out_valid_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic [WIDTH-1:0]   mcand_r, mcand_nxt_s;
    logic [WIDTH-1:0]   mplier_r, mplier_nxt_s;
    logic [WIDTH-1:0]   acc_r, acc_nxt_s;
    logic [CNT_W-1:0]   count_r, count_nxt_s;
    logic               mul_sf_r, mul_sf_nxt_s;

    logic               in_ready_s;
    logic               accept_s;
    logic [WIDTH-1:0]   add_x_s, add_y_s;
    logic               add_cin_s;
    logic [WIDTH:0]     sum_s;
    logic               is_arith_s;
    logic               force_flags_s;
    logic               alu_wr_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_c_s, alu_v_s;
    logic [3:0]         alu_flags_s;

    assign in_ready_s = (state_r == IDLE) || ((state_r == HOLD) && out_ready);
    assign accept_s   = in_valid && in_ready_s;

    // Single-cycle ALU; C for ADC/SBC/RSC comes from the committed flag register.
    always_comb begin
        add_x_s       = a;
        add_y_s       = b;
        add_cin_s     = 1'b0;
        is_arith_s    = 1'b0;
        force_flags_s = 1'b0;
        alu_wr_s      = 1'b1;
        alu_res_s     = {WIDTH{1'b0}};
        case (opcode)
            OP_AND: alu_res_s = a & b;
            OP_EOR: alu_res_s = a ^ b;
            OP_SUB: begin is_arith_s = 1'b1; add_y_s = ~b; add_cin_s = 1'b1; end
            OP_RSB: begin is_arith_s = 1'b1; add_x_s = b; add_y_s = ~a; add_cin_s = 1'b1; end
            OP_ADD: is_arith_s = 1'b1;
            OP_ADC: begin is_arith_s = 1'b1; add_cin_s = flags_r[1]; end
            OP_SBC: begin is_arith_s = 1'b1; add_y_s = ~b; add_cin_s = flags_r[1]; end
            OP_RSC: begin is_arith_s = 1'b1; add_x_s = b; add_y_s = ~a; add_cin_s = flags_r[1]; end
            OP_TST: begin alu_res_s = a & b; alu_wr_s = 1'b0; force_flags_s = 1'b1; end
            OP_TEQ: begin alu_res_s = a ^ b; alu_wr_s = 1'b0; force_flags_s = 1'b1; end
            OP_CMP: begin
                is_arith_s = 1'b1; add_y_s = ~b; add_cin_s = 1'b1;
                alu_wr_s = 1'b0; force_flags_s = 1'b1;
            end
            OP_CMN: begin is_arith_s = 1'b1; alu_wr_s = 1'b0; force_flags_s = 1'b1; end
            OP_ORR: alu_res_s = a | b;
            OP_MOV: alu_res_s = b;
            OP_BIC: alu_res_s = a & ~b;
            OP_MVN: alu_res_s = ~b;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
        sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{WIDTH{1'b0}}, add_cin_s};
        if (is_arith_s) begin
            alu_res_s = sum_s[WIDTH-1:0];
            alu_c_s   = sum_s[WIDTH];
            alu_v_s   = (add_x_s[WIDTH-1] == add_y_s[WIDTH-1]) &&
                        (sum_s[WIDTH-1] != add_x_s[WIDTH-1]);
        end else begin
            alu_c_s   = flags_r[1];
            alu_v_s   = flags_r[0];
        end
        alu_flags_s = {alu_res_s[WIDTH-1], (alu_res_s == {WIDTH{1'b0}}), alu_c_s, alu_v_s};
    end

    // Next-state and next-datapath values for the IDLE/MUL/HOLD controller.
    always_comb begin
        state_nxt_s     = state_r;
        result_nxt_s    = result_r;
        wr_en_nxt_s     = wr_en_r;
        flags_nxt_s     = flags_r;
        out_valid_nxt_s = out_valid_r;
        busy_nxt_s      = busy_r;
        mcand_nxt_s     = mcand_r;
        mplier_nxt_s    = mplier_r;
        acc_nxt_s       = acc_r;
        count_nxt_s     = count_r;
        mul_sf_nxt_s    = mul_sf_r;
        if (accept_s) begin
            if (is_mul) begin
                mcand_nxt_s     = a;
                mplier_nxt_s    = b;
                acc_nxt_s       = {WIDTH{1'b0}};
                count_nxt_s     = {CNT_W{1'b0}};
                mul_sf_nxt_s    = set_flags;
                busy_nxt_s      = 1'b1;
                out_valid_nxt_s = 1'b0;
                state_nxt_s     = MUL;
            end else begin
                result_nxt_s    = alu_res_s;
                wr_en_nxt_s     = alu_wr_s;
                out_valid_nxt_s = 1'b1;
                state_nxt_s     = HOLD;
                if (set_flags || force_flags_s) begin
                    flags_nxt_s = alu_flags_s;
                end else begin
                    flags_nxt_s = flags_r;
                end
            end
        end else begin
            case (state_r)
                IDLE: state_nxt_s = IDLE;
                MUL: begin
                    if (count_r == CNT_W'(WIDTH)) begin
                        result_nxt_s    = acc_r;
                        wr_en_nxt_s     = 1'b1;
                        out_valid_nxt_s = 1'b1;
                        busy_nxt_s      = 1'b0;
                        state_nxt_s     = HOLD;
                        if (mul_sf_r) begin
                            flags_nxt_s = {acc_r[WIDTH-1], (acc_r == {WIDTH{1'b0}}), flags_r[1:0]};
                        end else begin
                            flags_nxt_s = flags_r;
                        end
                    end else begin
                        if (mplier_r[0]) begin
                            acc_nxt_s = acc_r + mcand_r;
                        end else begin
                            acc_nxt_s = acc_r;
                        end
                        mcand_nxt_s  = mcand_r << 1;
                        mplier_nxt_s = mplier_r >> 1;
                        count_nxt_s  = count_r + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_nxt_s = 1'b0;
                        state_nxt_s     = IDLE;
                    end else begin
                        state_nxt_s     = HOLD;
                    end
                end
                default: begin
                    state_nxt_s     = IDLE;
                    out_valid_nxt_s = 1'b0;
                    busy_nxt_s      = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            result_r    <= {WIDTH{1'b0}};
            wr_en_r     <= 1'b0;
            flags_r     <= 4'b0000;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            mcand_r     <= {WIDTH{1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            mul_sf_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            result_r    <= result_nxt_s;
            wr_en_r     <= wr_en_nxt_s;
            flags_r     <= flags_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= busy_nxt_s;
            mcand_r     <= mcand_nxt_s;
            mplier_r    <= mplier_nxt_s;
            acc_r       <= acc_nxt_s;
            count_r     <= count_nxt_s;
            mul_sf_r    <= mul_sf_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign wr_en     = wr_en_r;
    assign flags     = flags_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32 with hand-computed results.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic        is_mul;
    logic        set_flags;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        wr_en;
    logic [3:0]  flags;
    logic        busy;

    int n_checks;
    int n_errors;

    alu_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .is_mul    (is_mul),
        .set_flags (set_flags),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .wr_en     (wr_en),
        .flags     (flags),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic m, input logic sf,
                        input logic [31:0] x, input logic [31:0] y);
        check("send_ready", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        opcode    = op;
        is_mul    = m;
        set_flags = sf;
        a         = x;
        b         = y;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        int  cyc;
        logic stall_ok;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = 4'h0;
        is_mul    = 1'b0;
        set_flags = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        out_ready = 1'b1;
        repeat (3) step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // ADD overflow, latency 1
        send(4'h4, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_result", 64'(result), 64'h8000_0000);
        check("add_flags", 64'(flags), 64'b1001);
        check("add_wr_en", 64'(wr_en), 64'd1);

        send(4'h2, 1'b0, 1'b1, 32'd5, 32'd5);
        check("sub_result", 64'(result), 64'd0);
        check("sub_flags", 64'(flags), 64'b0110);

        send(4'h5, 1'b0, 1'b0, 32'd1, 32'd1);
        check("adc_result", 64'(result), 64'd3);
        check("adc_flags", 64'(flags), 64'b0110);

        send(4'hA, 1'b0, 1'b0, 32'd3, 32'd4);
        check("cmp_wr_en", 64'(wr_en), 64'd0);
        check("cmp_result", 64'(result), 64'hFFFF_FFFF);
        check("cmp_flags", 64'(flags), 64'b1000);

        send(4'h4, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
        check("add2_result", 64'(result), 64'd0);
        check("add2_flags", 64'(flags), 64'b0111);

        // Multiply: C/V must survive, latency WIDTH+1
        send(4'h0, 1'b1, 1'b1, 32'h0001_0000, 32'h0001_0001);
        check("mul_busy", 64'(busy), 64'd1);
        check("mul_out_valid", 64'(out_valid), 64'd0);
        stall_ok = 1'b1;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            if (in_ready !== 1'b0) stall_ok = 1'b0;
            step();
            cyc++;
        end
        check("mul_in_ready_low", 64'(stall_ok), 64'd1);
        check("mul_latency", 64'(cyc), 64'd33);
        check("mul_result", 64'(result), 64'h0001_0000);
        check("mul_flags", 64'(flags), 64'b0011);
        check("mul_busy_done", 64'(busy), 64'd0);
        check("mul_wr_en", 64'(wr_en), 64'd1);

        // Backpressure with a pending request held by the requester
        send(4'h4, 1'b0, 1'b0, 32'h10, 32'h20);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        opcode    = 4'h2;
        is_mul    = 1'b0;
        set_flags = 1'b1;
        a         = 32'h30;
        b         = 32'h10;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_result", 64'(result), 64'h30);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_next_result", 64'(result), 64'h20);
        check("bp_next_valid", 64'(out_valid), 64'd1);
        check("bp_next_flags", 64'(flags), 64'b0010);

        // Logical ops keep C and V
        send(4'h0, 1'b0, 1'b1, 32'hF0, 32'h3C);
        check("and_result", 64'(result), 64'h30);
        check("and_flags", 64'(flags), 64'b0010);
        send(4'hF, 1'b0, 1'b1, 32'h0, 32'h0);
        check("mvn_result", 64'(result), 64'hFFFF_FFFF);
        check("mvn_flags", 64'(flags), 64'b1010);
        send(4'h8, 1'b0, 1'b0, 32'hF0, 32'h0F);
        check("tst_wr_en", 64'(wr_en), 64'd0);
        check("tst_flags", 64'(flags), 64'b0110);
        step();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset in the middle of a multiply
        send(4'h0, 1'b1, 1'b1, 32'd3, 32'd5);
        repeat (9) step();
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_flags", 64'(flags), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        check("arst_in_ready", 64'(in_ready), 64'd1);
        send(4'h0, 1'b0, 1'b0, 32'hF0, 32'h3C);
        check("post_and_result", 64'(result), 64'h30);
        check("post_and_flags", 64'(flags), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
